// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared constants and types for the timekeeper block.
//   - Adjust field codes (matching the 2-bit adj_field input encoding)
//   - Field maxima and widths for seconds, minutes and hours
//   - Set-handshake FSM state enum
package timekeeper_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_SEC  = 2'd1,
        ADJ_MIN  = 2'd2,
        ADJ_HOUR = 2'd3
    } adj_field_e;

    typedef enum logic {
        StReady  = 1'b0,
        StCommit = 1'b1
    } set_state_e;

endpackage

// File: rtl/timekeeper_mod_counter.sv
// mod_counter: modulo-(MAX+1) counter with load, clear and increment.
// Ports:
//   i_clk, i_rst    clock and synchronous active-high reset
//   i_en            counting increment (wraps MAX -> 0)
//   i_inc           adjust increment (same wrap, kept separate for clarity at the call site)
//   i_load/val      parallel load, highest priority
//   i_clr           clear to zero, below load
//   o_cnt           current count
//   o_wrap          combinational: count is at MAX, so the next increment wraps
module mod_counter #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_cnt_d = i_load_val;
        end else if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en || i_inc) begin
            w_cnt_d = (r_cnt == MaxVal) ? '0 : r_cnt + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == MaxVal);

endmodule

// File: rtl/timekeeper.sv
// timekeeper: single-clock time-of-day counter (h:m:s.subsec) with run/pause,
// validated set handshake, per-field adjust and 12h/24h hours output.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_run                         count enable
//   i_mode_12h                    hours output in 12h form
//   i_set_valid/o_set_ready       time-load handshake; i_set_hours/minutes/seconds payload
//   o_set_err                     pulse in the cycle after an out-of-range set is accepted
//   i_adj_strobe/i_adj_field      single-field increment
//   o_hours/o_pm/o_minutes/o_seconds/o_subsec   current time
//   o_s_tick/o_m_tick/o_h_tick/o_d_tick         registered carry strobes
module timekeeper
    import timekeeper_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned SUB_W = $clog2(TICKS_PER_SEC > 1 ? TICKS_PER_SEC : 2)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_mode_12h,
    input  logic              i_set_valid,
    output logic              o_set_ready,
    input  logic [HOUR_W-1:0] i_set_hours,
    input  logic [MIN_W-1:0]  i_set_minutes,
    input  logic [SEC_W-1:0]  i_set_seconds,
    output logic              o_set_err,
    input  logic              i_adj_strobe,
    input  logic [1:0]        i_adj_field,
    output logic [HOUR_W-1:0] o_hours,
    output logic              o_pm,
    output logic [MIN_W-1:0]  o_minutes,
    output logic [SEC_W-1:0]  o_seconds,
    output logic [SUB_W-1:0]  o_subsec,
    output logic              o_s_tick,
    output logic              o_m_tick,
    output logic              o_h_tick,
    output logic              o_d_tick
);

    set_state_e r_state, w_state_d;
    logic       r_set_err;
    logic       r_s_tick, r_m_tick, r_h_tick, r_d_tick;

    logic              w_accept, w_set_ok, w_load, w_adj, w_count;
    adj_field_e        w_adj_field;
    logic              w_sub_wrap, w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic              w_sub_en, w_sec_en, w_min_en, w_hour_en;
    logic [HOUR_W-1:0] w_h;
    logic [HOUR_W-1:0] w_hours;

    // Set FSM: a request is only taken in READY; COMMIT is a one-cycle cool-down.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StReady:  if (i_set_valid) w_state_d = StCommit;
            StCommit: w_state_d = StReady;
            default:  w_state_d = StReady;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StReady;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_accept = (r_state == StReady) && i_set_valid;
    assign w_set_ok = (i_set_hours <= HOUR_W'(HOUR_MAX)) &&
                      (i_set_minutes <= MIN_W'(MIN_MAX)) &&
                      (i_set_seconds <= SEC_W'(SEC_MAX));
    assign w_load   = w_accept && w_set_ok;

    // Priority: accepted set > adjust > counting.
    assign w_adj_field = adj_field_e'(i_adj_field);
    assign w_adj       = !w_accept && i_adj_strobe && (w_adj_field != ADJ_NONE);
    assign w_count     = i_run && !w_accept && !w_adj;

    // Whole carry chain resolves combinationally so the cascade lands on one edge.
    assign w_sub_en  = w_count;
    assign w_sec_en  = w_sub_en && w_sub_wrap;
    assign w_min_en  = w_sec_en && w_sec_wrap;
    assign w_hour_en = w_min_en && w_min_wrap;

    mod_counter #(
        .W   (SUB_W),
        .MAX (TICKS_PER_SEC - 1)
    ) u_subsec (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_sub_en),
        .i_inc      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_clr      (w_load || (w_adj && (w_adj_field == ADJ_SEC))),
        .o_cnt      (o_subsec),
        .o_wrap     (w_sub_wrap)
    );

    mod_counter #(
        .W   (SEC_W),
        .MAX (SEC_MAX)
    ) u_seconds (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_sec_en),
        .i_inc      (w_adj && (w_adj_field == ADJ_SEC)),
        .i_load     (w_load),
        .i_load_val (i_set_seconds),
        .i_clr      (1'b0),
        .o_cnt      (o_seconds),
        .o_wrap     (w_sec_wrap)
    );

    mod_counter #(
        .W   (MIN_W),
        .MAX (MIN_MAX)
    ) u_minutes (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_min_en),
        .i_inc      (w_adj && (w_adj_field == ADJ_MIN)),
        .i_load     (w_load),
        .i_load_val (i_set_minutes),
        .i_clr      (1'b0),
        .o_cnt      (o_minutes),
        .o_wrap     (w_min_wrap)
    );

    mod_counter #(
        .W   (HOUR_W),
        .MAX (HOUR_MAX)
    ) u_hours (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_hour_en),
        .i_inc      (w_adj && (w_adj_field == ADJ_HOUR)),
        .i_load     (w_load),
        .i_load_val (i_set_hours),
        .i_clr      (1'b0),
        .o_cnt      (w_h),
        .o_wrap     (w_hour_wrap)
    );

    // Ticks are registered so they coincide with the cycle the new value is visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_tick  <= 1'b0;
            r_m_tick  <= 1'b0;
            r_h_tick  <= 1'b0;
            r_d_tick  <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_s_tick  <= w_sec_en;
            r_m_tick  <= w_min_en;
            r_h_tick  <= w_hour_en;
            r_d_tick  <= w_hour_en && w_hour_wrap;
            r_set_err <= w_accept && !w_set_ok;
        end
    end

    always_comb begin
        w_hours = w_h;
        if (i_mode_12h) begin
            if (w_h == '0) begin
                w_hours = HOUR_W'(12);
            end else if (w_h > HOUR_W'(12)) begin
                w_hours = w_h - HOUR_W'(12);
            end
        end
    end

    // Held low while reset is asserted so no request can be advertised mid-reset.
    assign o_set_ready = (r_state == StReady) && !i_rst;
    assign o_set_err   = r_set_err;
    assign o_hours     = w_hours;
    assign o_pm        = (w_h >= HOUR_W'(12));
    assign o_s_tick    = r_s_tick;
    assign o_m_tick    = r_m_tick;
    assign o_h_tick    = r_h_tick;
    assign o_d_tick    = r_d_tick;

endmodule

// File: tb/tb_timekeeper.sv
module tb_timekeeper;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst, run, mode_12h, set_valid, adj_strobe;
    logic [4:0] set_hours;
    logic [5:0] set_minutes, set_seconds;
    logic [1:0] adj_field;
    logic       set_ready, set_err, pm, s_tick, m_tick, h_tick, d_tick;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] subsec;

    logic       rst1, run1;
    logic       set_ready1, set_err1, pm1, s_tick1, m_tick1, h_tick1, d_tick1;
    logic [4:0] hours1;
    logic [5:0] minutes1, seconds1;
    logic [0:0] subsec1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_mode_12h(mode_12h),
        .i_set_valid(set_valid), .o_set_ready(set_ready),
        .i_set_hours(set_hours), .i_set_minutes(set_minutes), .i_set_seconds(set_seconds),
        .o_set_err(set_err), .i_adj_strobe(adj_strobe), .i_adj_field(adj_field),
        .o_hours(hours), .o_pm(pm), .o_minutes(minutes), .o_seconds(seconds),
        .o_subsec(subsec), .o_s_tick(s_tick), .o_m_tick(m_tick), .o_h_tick(h_tick),
        .o_d_tick(d_tick)
    );

    timekeeper #(.TICKS_PER_SEC(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_run(run1), .i_mode_12h(1'b0),
        .i_set_valid(1'b0), .o_set_ready(set_ready1),
        .i_set_hours(5'd0), .i_set_minutes(6'd0), .i_set_seconds(6'd0),
        .o_set_err(set_err1), .i_adj_strobe(1'b0), .i_adj_field(2'd0),
        .o_hours(hours1), .o_pm(pm1), .o_minutes(minutes1), .o_seconds(seconds1),
        .o_subsec(subsec1), .o_s_tick(s_tick1), .o_m_tick(m_tick1), .o_h_tick(h_tick1),
        .o_d_tick(d_tick1)
    );

    function automatic void chk(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endfunction

    // Model: time of day as seconds since midnight plus a sub-second count.
    int m_tod = 0, m_sub = 0;
    bit m_ready = 1'b0, m_err = 1'b0, m_valid = 1'b0;
    bit m_st = 1'b0, m_mt = 1'b0, m_ht = 1'b0, m_dt = 1'b0;

    always @(posedge clk) begin
        int hh, mm, ss;
        bit acc;
        m_valid = 1'b1;
        hh = m_tod / 3600;
        mm = (m_tod / 60) % 60;
        ss = m_tod % 60;
        {m_st, m_mt, m_ht, m_dt} = 4'b0;
        m_err = 1'b0;
        if (rst) begin
            m_tod = 0; m_sub = 0; m_ready = 1'b1;
        end else begin
            acc = m_ready && set_valid;
            m_ready = !acc;
            if (acc) begin
                if (set_hours <= 23 && set_minutes <= 59 && set_seconds <= 59) begin
                    m_tod = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                    m_sub = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (adj_strobe && adj_field != 2'd0) begin
                case (adj_field)
                    2'd1: begin ss = (ss + 1) % 60; m_sub = 0; end
                    2'd2: mm = (mm + 1) % 60;
                    default: hh = (hh + 1) % 24;
                endcase
                m_tod = hh * 3600 + mm * 60 + ss;
            end else if (run) begin
                m_sub++;
                if (m_sub == TPS) begin
                    m_sub = 0;
                    m_tod = (m_tod + 1) % 86400;
                    m_st = 1'b1;
                    m_mt = (m_tod % 60 == 0);
                    m_ht = (m_tod % 3600 == 0);
                    m_dt = (m_tod == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        int h, eh;
        if (m_valid) begin
            h  = m_tod / 3600;
            eh = !mode_12h ? h : (h == 0 ? 12 : (h > 12 ? h - 12 : h));
            chk("m_hours", int'(hours), eh);
            chk("m_pm", int'(pm), int'(h >= 12));
            chk("m_minutes", int'(minutes), (m_tod / 60) % 60);
            chk("m_seconds", int'(seconds), m_tod % 60);
            chk("m_subsec", int'(subsec), m_sub);
            chk("m_ticks", int'({s_tick, m_tick, h_tick, d_tick}),
                int'({m_st, m_mt, m_ht, m_dt}));
            chk("m_set_ready", int'(set_ready), int'(m_ready && !rst));
            chk("m_set_err", int'(set_err), int'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        cyc();
        set_valid = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; set_valid = 1'b0; adj_strobe = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0; adj_field = '0;
        rst1 = 1'b1; run1 = 1'b1;

        // Reset and first second
        cyc();
        chk("ready_in_reset", int'(set_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(set_ready), 1);
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("subsec_seq", int'(subsec), i % 4);
            chk("s_tick_seq", int'(s_tick), int'(i == 4));
            chk("sec_seq", int'(seconds), int'(i == 4));
        end

        // Midnight rollover from a loaded 23:59:59
        run = 1'b0;
        set_valid = 1'b1; set_hours = 5'd23; set_minutes = 6'd59; set_seconds = 6'd59;
        cyc();
        set_valid = 1'b0; run = 1'b1;
        chk("load_h", int'(hours), 23);
        chk("load_ready", int'(set_ready), 0);
        repeat (3) cyc();
        cyc();
        chk("midnight_hms", int'({hours, minutes, seconds, subsec}), 0);
        chk("midnight_ticks", int'({s_tick, m_tick, h_tick, d_tick}), 4'hF);
        cyc();
        chk("post_midnight_ticks", int'({s_tick, m_tick, h_tick, d_tick}), 0);
        run = 1'b0;

        // Out-of-range set
        set_valid = 1'b1; set_hours = 5'd24; set_minutes = 6'd0; set_seconds = 6'd0;
        cyc();
        set_valid = 1'b0;
        chk("bad_set_err", int'(set_err), 1);
        chk("bad_set_ready", int'(set_ready), 0);
        chk("bad_set_subsec", int'(subsec), 1);
        cyc();
        chk("bad_set_err_clear", int'(set_err), 0);
        chk("bad_set_ready_back", int'(set_ready), 1);

        // Minute adjust at 59 does not carry
        set_time(10, 59, 30);
        adj_strobe = 1'b1; adj_field = 2'd2;
        cyc();
        adj_strobe = 1'b0;
        chk("adj_min_wrap", int'(minutes), 0);
        chk("adj_min_hours", int'(hours), 10);
        chk("adj_min_htick", int'(h_tick), 0);

        // Set beats a same-cycle hour adjust
        set_valid = 1'b1; set_hours = 5'd5; set_minutes = 6'd6; set_seconds = 6'd7;
        adj_strobe = 1'b1; adj_field = 2'd3;
        cyc();
        set_valid = 1'b0; adj_strobe = 1'b0;
        chk("set_wins", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 18367);
        cyc();

        // Seconds adjust clears subsec; strobe with field 0 lets counting run
        run = 1'b1;
        cyc(); cyc();
        adj_strobe = 1'b1; adj_field = 2'd1;
        cyc();
        chk("adj_sec", int'(seconds), 8);
        chk("adj_sec_subsec", int'(subsec), 0);
        adj_field = 2'd0;
        cyc();
        adj_strobe = 1'b0;
        chk("adj_none_counts", int'(subsec), 1);
        run = 1'b0;

        // 12h display
        mode_12h = 1'b1;
        set_time(0, 0, 0);
        chk("h12_midnight", int'({hours, pm}), (12 << 1) | 0);
        set_time(12, 0, 0);
        chk("h12_noon", int'({hours, pm}), (12 << 1) | 1);
        set_time(13, 0, 0);
        chk("h12_13", int'({hours, pm}), (1 << 1) | 1);
        mode_12h = 1'b0;
        #1;
        chk("h24_13", int'(hours), 13);
        mode_12h = 1'b1;
        #1;
        chk("h12_again", int'(hours), 1);
        mode_12h = 1'b0;

        // Mid-count reset
        run = 1'b1;
        repeat (6) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_fields", int'({hours, minutes, seconds, subsec}), 0);
        chk("rst_ticks", int'({s_tick, m_tick, h_tick, d_tick}), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", int'(set_ready), 1);
        cyc();
        chk("rst_resume", int'(subsec), 1);

        // One tick per second
        cyc();
        rst1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("tps1_sec", int'(seconds1), k);
            chk("tps1_stick", int'(s_tick1), 1);
            chk("tps1_subsec", int'(subsec1), 0);
        end

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timekeeper.md
Name: timekeeper

Overview:
- Parametrised, single-clock successor to the ripple-clocked hour/minute/second/sub-second counter chain.
- All fields advance on one clock edge using clock enables. No derived clocks, no dual-edge logic.
- Adds run/pause, a validated time-set handshake, per-field adjust, and a 12h/24h display mode.
- Feeds the display multiplexer and any alarm logic. Exports one-cycle tick strobes.

Parameters:
- TICKS_PER_SEC, 100: clk cycles per second when run=1. Legal range ≥1.
- SUB_W, $clog2(max(TICKS_PER_SEC,2)): width of the sub-second count. Derived; not overridden.

Ports:
- clk  in  1  sole clock, rising edge only
- rst  in  1  synchronous, active-high reset
- run  in  1  count enable; 0 = hold all fields
- mode_12h  in  1  1 = hours output in 12h form
- set_valid  in  1  time-load request
- set_ready  out  1  accepting a set this cycle
- set_hours  in  5  load value, 24h form (0–23)
- set_minutes  in  6  load value (0–59)
- set_seconds  in  6  load value (0–59)
- set_err  out  1  one-cycle pulse: last accepted set was out of range
- adj_strobe  in  1  single-field increment request
- adj_field  in  2  0 none, 1 seconds, 2 minutes, 3 hours
- hours  out  5  24h: 0–23; 12h: 1–12
- pm  out  1  internal hour ≥12, in both modes
- minutes  out  6  0–59
- seconds  out  6  0–59
- subsec  out  SUB_W  0..TICKS_PER_SEC-1
- s_tick, m_tick, h_tick, d_tick  out  1  one-cycle carry strobes

Behaviour:
- Reset (rst=1 at an edge; overrides everything, including mid-set or mid-adjust):
  - Internal hour, minutes, seconds, subsec = 0.
  - All ticks = 0, set_err = 0, set_ready = 0.
  - FSM → READY; set_ready = 1 from the first cycle after rst deasserts.
- Counting (run=1, no accepted set, no adj_strobe):
  - subsec increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and seconds increments on the same edge.
  - Seconds 59→0 increments minutes; minutes 59→0 increments hour; hour 23→0.
  - The whole cascade updates on one edge: 23:59:59.(N-1) → 00:00:00.0.
- Ticks:
  - Registered; high for exactly the one cycle in which the wrapped field first reads its new value.
  - s_tick on subsec wrap, m_tick on seconds wrap, h_tick on minutes wrap, d_tick on hour wrap.
  - At midnight all four are high together.
- TICKS_PER_SEC=1: subsec is constant 0; every enabled cycle advances seconds and raises s_tick.
- run=0: every field is held and no ticks are raised. Set and adjust still operate.
- Set FSM, states READY and COMMIT:
  - READY: set_ready=1. set_valid=1 is accepted at that edge → COMMIT.
  - COMMIT: set_ready=0 for exactly one cycle → READY. set_valid is ignored in COMMIT.
  - Valid request (hours ≤23, minutes ≤59, seconds ≤59): fields load at the accepting edge, subsec clears to 0, no ticks raised.
  - Invalid request: no field changes; set_err=1 during the COMMIT cycle.
  - An accepted set has top priority. Counting and adjust are suppressed in that cycle.
- Adjust (adj_strobe=1, field ≠0, no set accepted this cycle):
  - Targeted field +1, modulo its range (60 or 24). No carry into the next field. No tick raised.
  - Seconds adjust also clears subsec.
  - Counting is suppressed for that cycle, so subsec holds unless cleared.
  - adj_field=0 with strobe: no-op, and counting proceeds normally.
- Hours output, combinational from the internal hour h:
  - 24h mode: hours = h.
  - 12h mode: h=0 → 12; 1–11 → h; 12 → 12; 13–23 → h-12.
  - pm = (h ≥12) in both modes.
  - A mode_12h change is visible in the same cycle and never alters stored state.

Decomposition:
- Package timekeeper_pkg holds:
  - Adjust field codes: ADJ_NONE, ADJ_SEC, ADJ_MIN, ADJ_HOUR.
  - Field maxima: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths.
  - Set-FSM state enum.
- Sub-module mod_counter #(W, MAX):
  - Inputs: en, inc, load, load_val, clr.
  - Outputs: cnt, and a combinational wrap flag used as carry.
  - Instantiated four times: subsec, seconds, minutes, hours.
- The top level holds the set FSM, priority muxing, tick registers and 12h conversion.

Test Plan (TICKS_PER_SEC=4 unless stated):
- Reset, then run=1 for 4 cycles → subsec 0,1,2,3,0. s_tick high only in the cycle seconds first reads 1.
- Set 23:59:59 accepted, then run → after 4 cycles all fields read 0. s_tick, m_tick, h_tick, d_tick all high for that single cycle.
- set_valid with hours=24 → no field change; set_err=1 and set_ready=0 for the next cycle; set_ready=1 the cycle after.
- At minutes=59, adj_strobe with adj_field=2 → minutes=0, hours unchanged, no h_tick. Same-cycle set_valid in READY → set wins, adjust dropped.
- Internal hours 0, 12 and 13 with mode_12h=1 → hours/pm = 12/0, 12/1, 1/1. Toggling mode leaves internal state unchanged.
- Mid-count rst=1 for one cycle with run=1 → all fields 0, ticks 0, set_ready=1 on the following cycle. With TICKS_PER_SEC=1, seconds increments every cycle.
